// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : constants and tx state encoding shared by the UART core |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_if : byte handshake and serial line of the UART transmitter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface uart_tx_if;
  import uart_pkg::*;

  logic                      tx_valid;
  logic                      tx_ready;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx;
  logic                      tx_busy;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx,
    input  tx_busy
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx,
    output tx_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, pulses bit_done on last cycle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int                 c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_count;

  // Wrapping exactly at each bit boundary keeps bit edges drift-free.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == c_CNT_MAX) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  assign bit_done = (r_count == c_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx : 8-bit serial transmitter, start/8 data/[parity]/stop     |
// | Optional parity bit enabled by macro UART_TX_PARITY_EN. Rev 1.0    |
// +--------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int                 c_IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(UART_DATA_BITS - 1);

  tx_state_e                 r_state;
  logic                      r_tx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [c_IDX_W-1:0]        r_bit_idx;
  logic                      r_stop_idx;

  logic w_bit_done;
  logic w_baud_clear;
  logic w_last_stop;

  // Counter is held at zero while idle so START always begins on a fresh count.
  assign w_baud_clear = (r_state == S_IDLE);
  assign w_last_stop  = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_baud_clear),
    .bit_done (w_bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.tx_valid) begin
      r_parity <= (PARITY_ODD != 0) ? ~^bus.tx_data : ^bus.tx_data;
    end
  end
`else
  if (PARITY_ODD != 0) begin : g_parity_odd_ignored
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_valid) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_shift    <= bus.tx_data;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == c_LAST_BIT) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
              r_tx      <= r_parity;
`else
              r_state   <= S_STOP;
              r_tx      <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + c_IDX_W'(1);
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_done) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            if (w_last_stop) begin
              r_state    <= S_IDLE;
              r_stop_idx <= 1'b0;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.tx_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx : self-checking bench for uart_tx (STOP_BITS 1 and 2)   |
// | Parity frames checked when UART_TX_PARITY_EN is defined. Rev 1.0   |
// +--------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LEN1 = (10 + P + 1 - 1) * CPB;
  localparam int LEN2 = (10 + P + 2 - 1) * CPB;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rst_seen = 1'b1;
  int         n_cmp    = 0;
  int         n_err    = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  bit         m_active = 1'b0;
  int         m_idx    = 0;
  logic [7:0] m_cur    = 8'h00;

  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= reset;

  // Expected line level for cycle i of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input bit odd);
    int s;
    s = i / CPB;
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    if (P == 1 && s == 9) return odd ? ~^d : ^d;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send1(input logic [7:0] d, input bit hold);
    int t;
    bus1.tx_valid = 1'b1;
    bus1.tx_data  = d;
    t = 0;
    while (bus1.tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hs_ready", bus1.tx_ready, 1'b1);
    if (bus1.tx_ready === 1'b1) begin
      @(posedge clk);
      q1.push_back(d);
      @(negedge clk);
      bus1.tx_data = ~d;
    end
    if (!hold) bus1.tx_valid = 1'b0;
  endtask

  task automatic run2(input logic [7:0] d);
    logic [7:0] e;
    int t;
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = d;
    t = 0;
    while (bus2.tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("dut2_hs_ready", bus2.tx_ready, 1'b1);
    @(posedge clk);
    q2.push_back(d);
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = ~d;
    e = q2.pop_front();
    for (int i = 0; i < LEN2; i++) begin
      chk("dut2_tx", bus2.tx, exp_bit(e, i, 1'b1));
      chk("dut2_ready_low", bus2.tx_ready, 1'b0);
      @(negedge clk);
    end
    chk("dut2_idle_tx", bus2.tx, 1'b1);
    chk("dut2_idle_ready", bus2.tx_ready, 1'b1);
  endtask

  // Frame monitor for dut1: every cycle is either part of a queued frame or idle.
  initial begin : monitor
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        m_active = 1'b0;
        q1.delete();
        chk("rst_tx", bus1.tx, 1'b1);
        chk("rst_ready", bus1.tx_ready, 1'b1);
        chk("rst_busy", bus1.tx_busy, 1'b0);
      end else begin
        if (!m_active && q1.size() > 0) begin
          m_cur    = q1.pop_front();
          m_active = 1'b1;
          m_idx    = 0;
        end
        if (m_active) begin
          chk("frame_tx", bus1.tx, exp_bit(m_cur, m_idx, 1'b0));
          chk("frame_ready", bus1.tx_ready, 1'b0);
          chk("frame_busy", bus1.tx_busy, 1'b1);
          m_idx++;
          if (m_idx == LEN1) m_active = 1'b0;
        end else begin
          chk("idle_tx", bus1.tx, 1'b1);
          chk("idle_ready", bus1.tx_ready, 1'b1);
          chk("idle_busy", bus1.tx_busy, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    send1(8'hA5, 1'b0);
    repeat (45) @(negedge clk);

    send1(8'h00, 1'b1);
    send1(8'hFF, 1'b0);
    repeat (45) @(negedge clk);

    send1(8'h96, 1'b0);
    repeat (10) @(negedge clk);
    send1(8'h3C, 1'b0);
    repeat (45) @(negedge clk);

    send1(8'h55, 1'b0);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send1(8'h81, 1'b0);
    repeat (45) @(negedge clk);

    bus1.tx_valid = 1'b1;
    bus1.tx_data  = 8'hE7;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus1.tx_valid = 1'b0;
    repeat (5) @(negedge clk);

    send1(8'h07, 1'b0);
    repeat (45) @(negedge clk);

    run2(8'h07);
    run2(8'hC3);
    repeat (3) @(negedge clk);
    chk("q1_drained", (q1.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
